watch_core: RTL and testbench

//   Time-of-day core and 6-digit 7-segment scanner. Counts HH:MM:SS from the 1 s square wave
//   of the clock divider and scans one digit per clk_1k period. Mode/increment buttons set the time.

---
 rtl/watch_core.sv | 221 ++++++++++++++++++++++
 tb/tb_watch_core.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/watch_core.sv
// watch_core
//   Time-of-day counter (HH:MM:SS, BCD) with button-driven time setting and a
//   6-digit multiplexed 7-segment display scanner. Everything runs on clk_25M;
//   the divider outputs clk_1s / clk_1k are treated as level inputs and
//   edge-detected here, never used as clocks.
//
// Parameters
//   H24            1: 24 h (00..23); 0: 12 h (01..12), hour tens blanked when 0
//   SEG_ACTIVE_LOW 1: seg[7:0] inverted at the output register
//   COM_ACTIVE_LOW 1: selected com line driven 0, others 1
//
// Ports
//   clk_25M   in   system clock
//   reset     in   asynchronous, active-high
//   clk_1s    in   1 Hz square wave (clk_25M domain)
//   clk_1k    in   1 kHz square wave (clk_25M domain)
//   btn_mode  in   debounced level, asynchronous, 1 = pressed
//   btn_inc   in   debounced level, asynchronous, 1 = pressed
//   seg       out  {dp,g,f,e,d,c,b,a} of the selected digit
//   com       out  one-hot digit select, com[0] = hour tens .. com[5] = second ones
//   time_bcd  out  {h10,h1,m10,m1,s10,s1}
//   set_state out  0 RUN, 1 SET_H, 2 SET_M, 3 SET_S

module watch_core #(
    parameter logic H24            = 1'b1,
    parameter logic SEG_ACTIVE_LOW = 1'b0,
    parameter logic COM_ACTIVE_LOW = 1'b1
) (
    input  logic        clk_25M,
    input  logic        reset,
    input  logic        clk_1s,
    input  logic        clk_1k,
    input  logic        btn_mode,
    input  logic        btn_inc,
    output logic [7:0]  seg,
    output logic [5:0]  com,
    output logic [23:0] time_bcd,
    output logic [1:0]  set_state
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_SET_H = 2'd1;
    localparam logic [1:0] ST_SET_M = 2'd2;
    localparam logic [1:0] ST_SET_S = 2'd3;

    localparam logic [3:0] HOUR_T_RST = H24 ? 4'd0 : 4'd1;
    localparam logic [3:0] HOUR_O_RST = H24 ? 4'd0 : 4'd2;
    localparam logic [7:0] SEG_OFF    = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [5:0] COM_OFF    = COM_ACTIVE_LOW ? 6'h3F : 6'h00;

    logic       r_clk_1s_q, r_clk_1k_q;
    logic       r_mode_s1, r_mode_s2, r_mode_q;
    logic       r_inc_s1, r_inc_s2, r_inc_q;
    logic [1:0] r_state;
    logic [3:0] r_h10, r_h1, r_m10, r_m1, r_s10, r_s1;
    logic [2:0] r_dig;
    logic [7:0] r_seg;
    logic [5:0] r_com;

    logic       w_sec_tick, w_scan_tick, w_mode_p, w_inc_p;
    logic [1:0] w_state_next;
    logic [3:0] w_h10_next, w_h1_next, w_m10_next, w_m1_next, w_s10_next, w_s1_next;
    logic [8:0] w_sec_inc, w_min_inc;
    logic [7:0] w_hour_inc;
    logic [3:0] w_nibble;
    logic [6:0] w_pat;
    logic       w_dp, w_blank;
    logic [7:0] w_seg_act;
    logic [5:0] w_com_onehot;

    // Returns {wrap, tens, ones} of a 00..59 field advanced by one.
    function automatic logic [8:0] f_inc60(input logic [3:0] t, input logic [3:0] o);
        if (o != 4'd9)
            f_inc60 = {1'b0, t, o + 4'd1};
        else if (t != 4'd5)
            f_inc60 = {1'b0, t + 4'd1, 4'd0};
        else
            f_inc60 = 9'd0 | 9'h100;
    endfunction

    // Hour advanced by one with the wrap of the selected hour format.
    function automatic logic [7:0] f_inc_hour(input logic [3:0] t, input logic [3:0] o);
        if (H24 && t == 4'd2 && o == 4'd3)
            f_inc_hour = 8'h00;
        else if (!H24 && t == 4'd1 && o == 4'd2)
            f_inc_hour = 8'h01;
        else if (o == 4'd9)
            f_inc_hour = {t + 4'd1, 4'd0};
        else
            f_inc_hour = {t, o + 4'd1};
    endfunction

    function automatic logic [6:0] f_seg7(input logic [3:0] d);
        case (d)
            4'd0:    f_seg7 = 7'h3F;
            4'd1:    f_seg7 = 7'h06;
            4'd2:    f_seg7 = 7'h5B;
            4'd3:    f_seg7 = 7'h4F;
            4'd4:    f_seg7 = 7'h66;
            4'd5:    f_seg7 = 7'h6D;
            4'd6:    f_seg7 = 7'h7D;
            4'd7:    f_seg7 = 7'h07;
            4'd8:    f_seg7 = 7'h7F;
            4'd9:    f_seg7 = 7'h6F;
            default: f_seg7 = 7'h00;
        endcase
    endfunction

    assign w_sec_tick  = clk_1s & ~r_clk_1s_q;
    assign w_scan_tick = clk_1k & ~r_clk_1k_q;
    assign w_mode_p    = r_mode_s2 & ~r_mode_q;
    assign w_inc_p     = r_inc_s2 & ~r_inc_q;

    assign w_sec_inc  = f_inc60(r_s10, r_s1);
    assign w_min_inc  = f_inc60(r_m10, r_m1);
    assign w_hour_inc = f_inc_hour(r_h10, r_h1);

    always_comb begin
        w_state_next = r_state;
        w_h10_next   = r_h10;
        w_h1_next    = r_h1;
        w_m10_next   = r_m10;
        w_m1_next    = r_m1;
        w_s10_next   = r_s10;
        w_s1_next    = r_s1;
        // SET_S + 1 wraps to RUN, which gives the RUN->H->M->S->RUN cycle.
        if (w_mode_p)
            w_state_next = r_state + 2'd1;
        case (r_state)
            ST_RUN: begin
                if (w_sec_tick) begin
                    {w_s10_next, w_s1_next} = w_sec_inc[7:0];
                    if (w_sec_inc[8]) begin
                        {w_m10_next, w_m1_next} = w_min_inc[7:0];
                        if (w_min_inc[8])
                            {w_h10_next, w_h1_next} = w_hour_inc;
                    end
                end
            end
            // A mode press in the same cycle wins; the increment is dropped.
            ST_SET_H: if (w_inc_p && !w_mode_p) {w_h10_next, w_h1_next} = w_hour_inc;
            ST_SET_M: if (w_inc_p && !w_mode_p) {w_m10_next, w_m1_next} = w_min_inc[7:0];
            ST_SET_S: if (w_inc_p && !w_mode_p) {w_s10_next, w_s1_next} = 8'h00;
            default: ;
        endcase
    end

    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_com
            assign w_com_onehot[gi] = (r_dig == 3'(gi));
        end
    endgenerate

    always_comb begin
        case (r_dig)
            3'd0:    w_nibble = r_h10;
            3'd1:    w_nibble = r_h1;
            3'd2:    w_nibble = r_m10;
            3'd3:    w_nibble = r_m1;
            3'd4:    w_nibble = r_s10;
            default: w_nibble = r_s1;
        endcase
    end

    assign w_pat = f_seg7(w_nibble);
    assign w_dp  = (r_dig == 3'd1) || (r_dig == 3'd3);
    // Digit pairs {0,1},{2,3},{4,5} map onto SET_H/SET_M/SET_S via r_dig[2:1].
    assign w_blank = (!H24 && r_dig == 3'd0 && r_h10 == 4'd0) ||
                     (r_state != ST_RUN && r_dig[2:1] == (r_state - 2'd1) && !clk_1s);
    assign w_seg_act = w_blank ? {w_dp, 7'd0} : {w_dp, w_pat};

    always_ff @(posedge clk_25M or posedge reset) begin
        if (reset) begin
            r_clk_1s_q <= 1'b0;
            r_clk_1k_q <= 1'b0;
            r_mode_s1  <= 1'b0;
            r_mode_s2  <= 1'b0;
            r_mode_q   <= 1'b0;
            r_inc_s1   <= 1'b0;
            r_inc_s2   <= 1'b0;
            r_inc_q    <= 1'b0;
            r_state    <= ST_RUN;
            r_h10      <= HOUR_T_RST;
            r_h1       <= HOUR_O_RST;
            r_m10      <= 4'd0;
            r_m1       <= 4'd0;
            r_s10      <= 4'd0;
            r_s1       <= 4'd0;
            r_dig      <= 3'd0;
            r_seg      <= SEG_OFF;
            r_com      <= COM_OFF;
        end else begin
            r_clk_1s_q <= clk_1s;
            r_clk_1k_q <= clk_1k;
            r_mode_s1  <= btn_mode;
            r_mode_s2  <= r_mode_s1;
            r_mode_q   <= r_mode_s2;
            r_inc_s1   <= btn_inc;
            r_inc_s2   <= r_inc_s1;
            r_inc_q    <= r_inc_s2;
            r_state    <= w_state_next;
            r_h10      <= w_h10_next;
            r_h1       <= w_h1_next;
            r_m10      <= w_m10_next;
            r_m1       <= w_m1_next;
            r_s10      <= w_s10_next;
            r_s1       <= w_s1_next;
            if (w_scan_tick) begin
                r_seg <= SEG_ACTIVE_LOW ? ~w_seg_act : w_seg_act;
                r_com <= COM_ACTIVE_LOW ? ~w_com_onehot : w_com_onehot;
                r_dig <= (r_dig == 3'd5) ? 3'd0 : r_dig + 3'd1;
            end
        end
    end

    assign seg       = r_seg;
    assign com       = r_com;
    assign time_bcd  = {r_h10, r_h1, r_m10, r_m1, r_s10, r_s1};
    assign set_state = r_state;

endmodule

// File: tb/tb_watch_core.sv
// Bench for watch_core: two instances (24 h / active-high seg / active-low com
// and 12 h / active-low seg / active-high com) share the stimulus. A behavioural
// model holds the time as plain integers and is compared every cycle; directed
// literal checks pin the model to hand-computed values.

module tb_watch_core;

    logic        clk_25M = 1'b0;
    logic        reset, clk_1s, clk_1k, btn_mode, btn_inc;
    logic [7:0]  seg_a, seg_b;
    logic [5:0]  com_a, com_b;
    logic [23:0] tb_a, tb_b;
    logic [1:0]  st_a, st_b;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 clk_25M = ~clk_25M;

    watch_core #(.H24(1'b1), .SEG_ACTIVE_LOW(1'b0), .COM_ACTIVE_LOW(1'b1)) dut24 (
        .clk_25M(clk_25M), .reset(reset), .clk_1s(clk_1s), .clk_1k(clk_1k),
        .btn_mode(btn_mode), .btn_inc(btn_inc),
        .seg(seg_a), .com(com_a), .time_bcd(tb_a), .set_state(st_a));

    watch_core #(.H24(1'b0), .SEG_ACTIVE_LOW(1'b1), .COM_ACTIVE_LOW(1'b0)) dut12 (
        .clk_25M(clk_25M), .reset(reset), .clk_1s(clk_1s), .clk_1k(clk_1k),
        .btn_mode(btn_mode), .btn_inc(btn_inc),
        .seg(seg_b), .com(com_b), .time_bcd(tb_b), .set_state(st_b));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         m_hh[2], m_mm[2], m_ss[2], m_md[2], m_dig[2];
    logic [7:0] m_seg[2];
    logic [5:0] m_com[2];
    bit         p1s, p1k, bm1, bm2, bm3, bi1, bi2, bi3;
    bit         t_st, t_sk, t_mp, t_ip;
    int         dv[6];
    logic [7:0] pat;

    function automatic logic [6:0] f7(input int d);
        case (d)
            0: f7 = 7'h3F; 1: f7 = 7'h06; 2: f7 = 7'h5B; 3: f7 = 7'h4F; 4: f7 = 7'h66;
            5: f7 = 7'h6D; 6: f7 = 7'h7D; 7: f7 = 7'h07; 8: f7 = 7'h7F; default: f7 = 7'h6F;
        endcase
    endfunction

    function automatic logic [23:0] mbcd(input int u);
        mbcd = {4'(m_hh[u] / 10), 4'(m_hh[u] % 10), 4'(m_mm[u] / 10),
                4'(m_mm[u] % 10), 4'(m_ss[u] / 10), 4'(m_ss[u] % 10)};
    endfunction

    function automatic int next_hour(input int u, input int h);
        next_hour = (u == 0) ? (h + 1) % 24 : (h % 12) + 1;
    endfunction

    initial forever begin
        @(posedge clk_25M or posedge reset);
        if (reset) begin
            for (int u = 0; u < 2; u++) begin
                m_hh[u] = (u == 0) ? 0 : 12;
                m_mm[u] = 0; m_ss[u] = 0; m_md[u] = 0; m_dig[u] = 0;
                m_seg[u] = (u == 1) ? 8'hFF : 8'h00;
                m_com[u] = (u == 0) ? 6'h3F : 6'h00;
            end
            p1s = 0; p1k = 0; bm1 = 0; bm2 = 0; bm3 = 0; bi1 = 0; bi2 = 0; bi3 = 0;
        end else begin
            t_st = clk_1s && !p1s;
            t_sk = clk_1k && !p1k;
            // a button level seen at edge k acts at edge k+2 if it was low one edge earlier
            t_mp = bm2 && !bm3;
            t_ip = bi2 && !bi3;
            for (int u = 0; u < 2; u++) begin
                if (t_sk) begin
                    dv[0] = m_hh[u] / 10; dv[1] = m_hh[u] % 10;
                    dv[2] = m_mm[u] / 10; dv[3] = m_mm[u] % 10;
                    dv[4] = m_ss[u] / 10; dv[5] = m_ss[u] % 10;
                    pat = {1'b0, f7(dv[m_dig[u]])};
                    if (m_dig[u] == 1 || m_dig[u] == 3) pat[7] = 1'b1;
                    if ((m_dig[u] == 0 && u == 1 && m_hh[u] < 10) ||
                        (m_md[u] != 0 && m_dig[u] / 2 == m_md[u] - 1 && !clk_1s))
                        pat[6:0] = 7'd0;
                    m_seg[u] = (u == 1) ? ~pat : pat;
                    m_com[u] = (u == 0) ? ~(6'd1 << m_dig[u]) : (6'd1 << m_dig[u]);
                    m_dig[u] = (m_dig[u] + 1) % 6;
                end
                case (m_md[u])
                    0: if (t_st) begin
                        m_ss[u] = (m_ss[u] + 1) % 60;
                        if (m_ss[u] == 0) begin
                            m_mm[u] = (m_mm[u] + 1) % 60;
                            if (m_mm[u] == 0) m_hh[u] = next_hour(u, m_hh[u]);
                        end
                    end
                    1: if (t_ip && !t_mp) m_hh[u] = next_hour(u, m_hh[u]);
                    2: if (t_ip && !t_mp) m_mm[u] = (m_mm[u] + 1) % 60;
                    default: if (t_ip && !t_mp) m_ss[u] = 0;
                endcase
                if (t_mp) m_md[u] = (m_md[u] + 1) % 4;
            end
            p1s = clk_1s; p1k = clk_1k;
            bm3 = bm2; bm2 = bm1; bm1 = btn_mode;
            bi3 = bi2; bi2 = bi1; bi1 = btn_inc;
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk_25M);
        if (cmp_en) begin
            chk("time24", tb_a, mbcd(0));
            chk("time12", tb_b, mbcd(1));
            chk("state24", st_a, 32'(m_md[0]));
            chk("state12", st_b, 32'(m_md[1]));
            chk("seg24", seg_a, m_seg[0]);
            chk("seg12", seg_b, m_seg[1]);
            chk("com24", com_a, m_com[0]);
            chk("com12", com_b, m_com[1]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk_25M);
        #1;
    endtask

    task automatic press(input bit m, input bit i);
        btn_mode = m; btn_inc = i;
        cyc(4);
        btn_mode = 0; btn_inc = 0;
        cyc(4);
    endtask

    task automatic sec();
        clk_1s = 1; cyc(3);
        clk_1s = 0; cyc(3);
    endtask

    task automatic scan();
        clk_1k = 1; cyc(2);
        clk_1k = 0; cyc(2);
    endtask

    logic [7:0] seg_exp[6];
    logic [5:0] ecom;

    initial begin
        reset = 1; clk_1s = 0; clk_1k = 0; btn_mode = 0; btn_inc = 0;
        seg_exp[0] = 8'h06; seg_exp[1] = 8'hDB; seg_exp[2] = 8'h4F;
        seg_exp[3] = 8'hE6; seg_exp[4] = 8'h6D; seg_exp[5] = 8'h7D;
        cyc(3);
        cmp_en = 1;
        chk("rst_time24", tb_a, 24'h000000);
        chk("rst_state24", st_a, 2'd0);
        chk("rst_com24", com_a, 6'h3F);
        chk("rst_seg24", seg_a, 8'h00);
        chk("rst_time12", tb_b, 24'h120000);
        chk("rst_seg12", seg_b, 8'hFF);
        chk("rst_com12", com_b, 6'h00);
        reset = 0; cyc(4);

        // set 23:59:00 (12 h unit lands on 11:59:00)
        press(1, 0); repeat (23) press(0, 1);
        press(1, 0); repeat (59) press(0, 1);
        press(1, 0); press(0, 1); press(1, 0);
        repeat (58) sec();
        chk("t_235958", tb_a, 24'h235958);
        chk("t12_115958", tb_b, 24'h115958);
        sec();
        chk("t_235959", tb_a, 24'h235959);
        clk_1s = 1;
        chk("tick_cycle_old", tb_a, 24'h235959);
        cyc(1);
        chk("wrap_000000", tb_a, 24'h000000);
        chk("wrap12_120000", tb_b, 24'h120000);
        cyc(2); clk_1s = 0; cyc(3);

        // 00:59:00 / 12:59:00 then roll the hour
        press(1, 0); press(1, 0); repeat (59) press(0, 1);
        press(1, 0); press(0, 1); press(1, 0);
        repeat (59) sec();
        chk("t12_125959", tb_b, 24'h125959);
        sec();
        chk("t12_010000", tb_b, 24'h010000);
        chk("t_010000", tb_a, 24'h010000);
        scan();
        chk("h10_blank_com12", com_b, 6'b000001);
        chk("h10_blank_seg12", seg_b, 8'hFF);
        repeat (5) scan();

        // reach 22:10:30
        press(1, 0); repeat (21) press(0, 1);
        press(1, 0); repeat (10) press(0, 1);
        press(1, 0); press(0, 1); press(1, 0);
        repeat (30) sec();
        chk("t_221030", tb_a, 24'h221030);
        chk("t12_101030", tb_b, 24'h101030);
        press(1, 0);
        chk("state_set_h", st_a, 2'd1);
        repeat (5) press(0, 1);
        chk("t_031030", tb_a, 24'h031030);
        chk("t12_031030", tb_b, 24'h031030);
        press(1, 0); press(1, 0); press(0, 1);
        chk("state_set_s", st_a, 2'd3);
        chk("sec_clear", tb_a, 24'h031000);
        press(1, 0);
        chk("state_run", st_a, 2'd0);
        chk("min_untouched", tb_a, 24'h031000);
        press(1, 1);
        chk("simul_state", st_a, 2'd1);
        chk("simul_hours", tb_a, 24'h031000);
        press(1, 0); press(0, 1);
        chk("set_m_inc", tb_a, 24'h031100);
        reset = 1; cyc(2); reset = 0; cyc(2);
        chk("midset_rst_state", st_a, 2'd0);
        chk("midset_rst_time", tb_a, 24'h000000);
        chk("midset_rst_time12", tb_b, 24'h120000);

        // 12:34:56 then scan walk
        press(1, 0); repeat (12) press(0, 1);
        press(1, 0); repeat (34) press(0, 1);
        press(1, 0); press(0, 1); press(1, 0);
        repeat (56) sec();
        chk("t_123456", tb_a, 24'h123456);
        for (int k = 0; k < 6; k++) begin
            scan();
            ecom = ~(6'd1 << k);
            chk("scan_com", com_a, ecom);
            chk("scan_seg", seg_a, seg_exp[k]);
        end
        scan();
        chk("scan_wrap_com", com_a, 6'b111110);
        chk("scan_wrap_seg", seg_a, 8'h06);

        // randomized phase
        for (int n = 0; n < 8000; n++) begin
            if ($urandom_range(0, 39) == 0) clk_1s = ~clk_1s;
            if ($urandom_range(0, 7) == 0) clk_1k = ~clk_1k;
            if ($urandom_range(0, 59) == 0) btn_mode = ~btn_mode;
            if ($urandom_range(0, 14) == 0) btn_inc = ~btn_inc;
            reset = ($urandom_range(0, 2999) == 0);
            cyc(1);
        end
        reset = 0;
        cyc(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
